// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the framed SPI master.
//   state_e   : master FSM states
//   MSGID_W   : width of the frame header compared against MSGID
//   cnt_width : bits needed to hold the values 0..max_val
package spi_frame_pkg;

  localparam int unsigned MSGID_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_frame_clkgen.sv
// sclk phase generator: counts CLK_DIV cycles per half period while enabled.
// Phase starts in the high half whenever enable rises, so the first edge the
// FSM sees after SETUP is always a rising one.
//   clk, rst    : system clock, synchronous active-high reset
//   en          : run the phase counter (cleared whenever low)
//   hi_first_c  : first cycle of a high half period
//   fall_tick_c : last cycle of a high half period (sclk falls next)
//   rise_tick_c : last cycle of a low half period (sclk rises next)
module spi_frame_clkgen
  import spi_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic hi_first_c,
  output logic fall_tick_c,
  output logic rise_tick_c
);

  localparam int unsigned PH_W = cnt_width(CLK_DIV);

  logic [PH_W-1:0] ph_cnt;
  logic            lo_phase;
  logic            ph_last_c;

  assign ph_last_c = (ph_cnt == PH_W'(CLK_DIV - 1));

  // Half-period counter and phase flag
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      ph_cnt   <= '0;
      lo_phase <= 1'b0;
    end else if (ph_last_c) begin
      ph_cnt   <= '0;
      lo_phase <= ~lo_phase;
    end else begin
      ph_cnt   <= ph_cnt + PH_W'(1);
    end
  end

  assign hi_first_c  = en && !lo_phase && (ph_cnt == '0);
  assign fall_tick_c = en && !lo_phase && ph_last_c;
  assign rise_tick_c = en &&  lo_phase && ph_last_c;

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master for one fixed-length frame per request. Sends tx_data MSB
// first on mosi, captures the reply from miso and flags whether its top
// MSGID_W bits match MSGID.
//   clk, rst        : system clock, synchronous active-high reset
//   start, tx_data  : frame request, accepted only while idle
//   rx_data         : last received frame (held until the next done)
//   done            : frame complete pulse; rx_valid / msgid_err qualify it
//   busy            : frame in progress including the inter-frame gap
//   sclk, mosi, sel : SPI outputs (sel active low); miso : SPI input
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int unsigned           BUFFER_SIZE = 64,
  parameter logic [MSGID_W-1:0]    MSGID       = 32'h74697277,
  parameter int unsigned           CLK_DIV     = 4,
  parameter int unsigned           CS_SETUP    = 4,
  parameter int unsigned           CS_HOLD     = 4,
  parameter int unsigned           CS_GAP      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   done,
  output logic                   rx_valid,
  output logic                   msgid_err,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic                   sel
);

  localparam int unsigned CNT_W   = cnt_width(BUFFER_SIZE);
  localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD) ?
                                    ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                    ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BUFFER_SIZE-1:0] tx_sr_q, tx_sr_d;
  logic [BUFFER_SIZE-1:0] rx_sr_q, rx_sr_d;
  logic [BUFFER_SIZE-1:0] rx_data_d;
  logic [BUFFER_SIZE-1:0] tx_shift_c;
  logic                   sel_d, sclk_d, mosi_d, busy_d;
  logic                   done_d, rx_valid_d, msgid_err_d;
  logic                   clk_en_c, hdr_match_c;
  logic                   hi_first_c, fall_tick_c, rise_tick_c;

  assign clk_en_c    = (state_q == SHIFT_HI) || (state_q == SHIFT_LO);
  assign tx_shift_c  = tx_sr_q << 1;
  assign hdr_match_c = (rx_sr_q[BUFFER_SIZE-1 -: MSGID_W] == MSGID);

  spi_frame_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .en          (clk_en_c),
    .hi_first_c  (hi_first_c),
    .fall_tick_c (fall_tick_c),
    .rise_tick_c (rise_tick_c)
  );

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data   <= '0;
      sel       <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_valid  <= 1'b0;
      msgid_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data   <= rx_data_d;
      sel       <= sel_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      busy      <= busy_d;
      done      <= done_d;
      rx_valid  <= rx_valid_d;
      msgid_err <= msgid_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data;
    sel_d       = sel;
    sclk_d      = sclk;
    mosi_d      = mosi;
    busy_d      = busy;
    done_d      = 1'b0;
    rx_valid_d  = 1'b0;
    msgid_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          tmr_d     = '0;
          sel_d     = 1'b0;
          mosi_d    = tx_data[BUFFER_SIZE-1];
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
          tmr_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
      end

      SHIFT_HI: begin
        if (hi_first_c) begin
          rx_sr_d = {rx_sr_q[BUFFER_SIZE-2:0], miso};
        end
        if (fall_tick_c) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          sclk_d    = 1'b0;
          // Last rising edge already issued: park mosi high and close out
          if (bit_cnt_q == CNT_W'(BUFFER_SIZE - 1)) begin
            mosi_d  = 1'b1;
            state_d = HOLD;
          end else begin
            tx_sr_d = tx_shift_c;
            mosi_d  = tx_shift_c[BUFFER_SIZE-1];
            state_d = SHIFT_LO;
          end
        end
      end

      SHIFT_LO: begin
        if (rise_tick_c) begin
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end

      HOLD: begin
        if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
          tmr_d       = '0;
          rx_data_d   = rx_sr_q;
          done_d      = 1'b1;
          rx_valid_d  = hdr_match_c;
          msgid_err_d = !hdr_match_c;
          sel_d       = 1'b1;
          state_d     = GAP;
        end else begin
          tmr_d       = tmr_q + TMR_W'(1);
        end
      end

      GAP: begin
        if (tmr_q == TMR_W'(CS_GAP - 1)) begin
          tmr_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: 64-bit and 32-bit instances, each talking to a
// behavioural slave that loads its reply on sel falling, shifts it out on
// sclk falling and captures mosi on sclk rising.
module tb_spi_frame_master;

  localparam int unsigned B64      = 64;
  localparam int unsigned B32      = 32;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CS_SETUP = 4;
  localparam int unsigned CS_HOLD  = 4;
  localparam int unsigned CS_GAP   = 8;
  localparam logic [31:0] MSGID    = 32'h74697277;

  localparam int FRAME64 = CS_SETUP + (2 * B64 - 1) * CLK_DIV + CS_HOLD;
  localparam int FRAME32 = CS_SETUP + (2 * B32 - 1) * CLK_DIV + CS_HOLD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // 64-bit instance
  logic          start = 1'b0;
  logic [63:0]   tx_data = '0;
  logic [63:0]   rx_data;
  logic          done, rx_valid, msgid_err, busy, sclk, mosi, sel;
  logic          miso = 1'b0;

  // 32-bit instance
  logic          start32 = 1'b0;
  logic [31:0]   tx_data32 = '0;
  logic [31:0]   rx_data32;
  logic          done32, rx_valid32, msgid_err32, busy32, sclk32, mosi32, sel32;
  logic          miso32 = 1'b0;

  spi_frame_master #(
    .BUFFER_SIZE (B64), .MSGID (MSGID), .CLK_DIV (CLK_DIV),
    .CS_SETUP (CS_SETUP), .CS_HOLD (CS_HOLD), .CS_GAP (CS_GAP)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .tx_data (tx_data),
    .rx_data (rx_data), .done (done), .rx_valid (rx_valid),
    .msgid_err (msgid_err), .busy (busy), .sclk (sclk), .mosi (mosi),
    .miso (miso), .sel (sel)
  );

  spi_frame_master #(
    .BUFFER_SIZE (B32), .MSGID (MSGID), .CLK_DIV (CLK_DIV),
    .CS_SETUP (CS_SETUP), .CS_HOLD (CS_HOLD), .CS_GAP (CS_GAP)
  ) dut32 (
    .clk (clk), .rst (rst), .start (start32), .tx_data (tx_data32),
    .rx_data (rx_data32), .done (done32), .rx_valid (rx_valid32),
    .msgid_err (msgid_err32), .busy (busy32), .sclk (sclk32), .mosi (mosi32),
    .miso (miso32), .sel (sel32)
  );

  int total = 0;
  int bad   = 0;

  // Slave model and timing monitor for the 64-bit link
  logic [63:0] reply64 = '0, s_sr64 = '0, s_rx64 = '0;
  logic        prev_sel = 1'b1, prev_sclk = 1'b0;
  int rise64 = 0, hi_bad64 = 0, sclk_sel_bad64 = 0, done_cnt64 = 0;
  int sel_fall64 = 0, sel_rise64 = 0, first_rise64 = 0, last_rise64 = 0;
  int last_fall64 = 0, done_cyc64 = 0;

  always @(negedge clk) begin
    if (prev_sel && !sel) begin
      sel_fall64 = cyc; rise64 = 0; hi_bad64 = 0;
      s_sr64 = reply64; s_rx64 = '0; miso = s_sr64[63];
    end
    if (!prev_sel && sel) sel_rise64 = cyc;
    if (!prev_sclk && sclk) begin
      if (rise64 == 0) first_rise64 = cyc;
      rise64 = rise64 + 1; last_rise64 = cyc;
      s_rx64 = {s_rx64[62:0], mosi};
    end
    if (prev_sclk && !sclk) begin
      if (cyc - last_rise64 != int'(CLK_DIV)) hi_bad64 = hi_bad64 + 1;
      last_fall64 = cyc;
      s_sr64 = s_sr64 << 1; miso = s_sr64[63];
    end
    if (sel && sclk) sclk_sel_bad64 = sclk_sel_bad64 + 1;
    if (done) begin done_cyc64 = cyc; done_cnt64 = done_cnt64 + 1; end
    prev_sel = sel; prev_sclk = sclk;
  end

  // Slave model for the 32-bit link
  logic [31:0] reply32 = '0, s_sr32 = '0, s_rx32 = '0;
  logic        prev_sel32 = 1'b1, prev_sclk32 = 1'b0;
  int rise32 = 0, sel_fall32 = 0, done_cyc32 = 0;

  always @(negedge clk) begin
    if (prev_sel32 && !sel32) begin
      sel_fall32 = cyc; rise32 = 0; s_sr32 = reply32; s_rx32 = '0; miso32 = s_sr32[31];
    end
    if (!prev_sclk32 && sclk32) begin
      rise32 = rise32 + 1; s_rx32 = {s_rx32[30:0], mosi32};
    end
    if (prev_sclk32 && !sclk32) begin
      s_sr32 = s_sr32 << 1; miso32 = s_sr32[31];
    end
    if (done32) done_cyc32 = cyc;
    prev_sel32 = sel32; prev_sclk32 = sclk32;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done64(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin tick(); n++; end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic wait_idle64(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Expected results from the link rules: reply lands in rx_data, header
  // decides rx_valid/msgid_err, slave sees tx, plus frame timing.
  task automatic check_frame64(input string tag, input logic [63:0] tx, input logic [63:0] reply);
    logic ok;
    ok = (reply[63:32] == MSGID);
    chk({tag, "_rx_data"},   rx_data, reply);
    chk({tag, "_rx_valid"},  64'(rx_valid), 64'(ok));
    chk({tag, "_msgid_err"}, 64'(msgid_err), 64'(!ok));
    chk({tag, "_slave_rx"},  s_rx64, tx);
    chk({tag, "_rises"},     64'(rise64), 64'(B64));
    chk({tag, "_hi_width"},  64'(hi_bad64), 64'd0);
    chk({tag, "_setup"},     64'(first_rise64 - sel_fall64), 64'(CS_SETUP));
    chk({tag, "_frame_len"}, 64'(done_cyc64 - sel_fall64), 64'(FRAME64));
    chk({tag, "_hold"},      64'(sel_rise64 - last_fall64), 64'(CS_HOLD));
    chk({tag, "_sel_hi"},    64'(sel), 64'd1);
  endtask

  task automatic run64(input string tag, input logic [63:0] tx, input logic [63:0] reply);
    reply64 = reply; tx_data = tx; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done64(tag);
    check_frame64(tag, tx, reply);
    wait_idle64(tag);
  endtask

  initial begin
    logic [63:0] tx1, tx2, rep;
    int n, d0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_sel", 64'(sel), 64'd1);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'({done, rx_valid, msgid_err}), 64'd0);
    chk("rst_rx_data", rx_data, 64'd0);
    chk("rst32_sel_sclk_mosi", 64'({sel32, sclk32, mosi32}), 64'b101);
    rst = 1'b0;
    repeat (2) tick();

    // Directed loopback and header-mismatch frames
    run64("loop", 64'h74697277_01020304, 64'h74697277_DEADBEEF);
    run64("err", 64'h74697277_0A0B0C0D, 64'h00000000_12345678);

    // Random frames, header matching roughly half the time
    for (int i = 0; i < 4; i++) begin
      tx1 = {$urandom, $urandom};
      rep = {(($urandom_range(0, 1) == 1) ? MSGID : 32'($urandom)), 32'($urandom)};
      run64($sformatf("rnd%0d", i), tx1, rep);
    end

    // start held high throughout: one frame, next accepted only after the gap
    tx1 = {MSGID, 32'($urandom)};
    tx2 = {MSGID, 32'($urandom)};
    reply64 = {MSGID, 32'h0BADF00D};
    d0 = done_cnt64;
    tx_data = tx1; start = 1'b1;
    tick();
    tx_data = tx2;
    wait_done64("b2b1");
    chk("b2b1_slave_rx", s_rx64, tx1);
    chk("b2b1_busy_in_gap", 64'(busy), 64'd1);
    n = 0;
    while (sel !== 1'b0 && n < 100) begin tick(); n++; end
    chk("b2b_gap_len", 64'(sel_fall64 - sel_rise64), 64'(CS_GAP + 1));
    chk("b2b_one_frame", 64'(done_cnt64 - d0), 64'd1);
    start = 1'b0;
    wait_done64("b2b2");
    check_frame64("b2b2", tx2, {MSGID, 32'h0BADF00D});
    wait_idle64("b2b2");
    repeat (40) tick();
    chk("b2b_no_third", 64'({sel, busy}), 64'b10);
    chk("b2b_frame_count", 64'(done_cnt64 - d0), 64'd2);
    chk("sclk_low_when_deselected", 64'(sclk_sel_bad64), 64'd0);

    // Reset in the middle of a frame
    reply64 = {MSGID, 32'h55AA55AA};
    tx_data = {$urandom, $urandom}; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rise64 < 21 && n < 1000) begin tick(); n++; end
    chk("midrst_in_frame", 64'({sel, busy}), 64'b01);
    d0 = done_cnt64;
    rst = 1'b1;
    tick();
    chk("midrst_sel_sclk_mosi", 64'({sel, sclk, mosi}), 64'b101);
    chk("midrst_busy_done", 64'({busy, done}), 64'd0);
    chk("midrst_rx_data", rx_data, 64'd0);
    rst = 1'b0;
    repeat (600) tick();
    chk("midrst_no_done", 64'(done_cnt64 - d0), 64'd0);
    run64("post_rst", {$urandom, $urandom}, {MSGID, 32'($urandom)});

    // 32-bit frame
    reply32 = MSGID; tx_data32 = MSGID; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    n = 0;
    while (done32 !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("b32_done", 64'(done32), 64'd1);
    chk("b32_rx_data", 64'(rx_data32), 64'(MSGID));
    chk("b32_flags", 64'({rx_valid32, msgid_err32}), 64'b10);
    chk("b32_rises", 64'(rise32), 64'(B32));
    chk("b32_slave_rx", 64'(s_rx32), 64'(MSGID));
    chk("b32_frame_len", 64'(done_cyc32 - sel_fall32), 64'(FRAME32));

    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- SPI master that drives the host side of the framed SPI link served by the FPGA-side slave.
- Shifts one fixed-length frame (MSGID in the top 32 bits) out on mosi and captures the slave's reply frame from miso.
- Flags whether the reply header matches MSGID.
- Used for board-to-board links and for bench loopback against the slave.

Parameters:
- BUFFER_SIZE, 64, frame length in bits, both directions; must be >= 32.
- MSGID, 32'h74697277, header checked in bits [BUFFER_SIZE-1:BUFFER_SIZE-32] of the reply.
- CLK_DIV, 4, sclk half-period in clk cycles; must be >= 4 because the slave synchronizes sclk with 3 flops.
- CS_SETUP, 4, clk cycles from sel falling to the first sclk rising edge.
- CS_HOLD, 4, clk cycles from the last sclk falling edge to sel rising.
- CS_GAP, 8, minimum clk cycles sel stays high between frames.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; accepted only when busy=0
- tx_data  in  BUFFER_SIZE  frame to send; sampled on the start-accept cycle
- rx_data  out  BUFFER_SIZE  last received frame
- done  out  1  one-cycle pulse when a frame completes
- rx_valid  out  1  one-cycle pulse with done when the reply header equals MSGID
- msgid_err  out  1  one-cycle pulse with done when the reply header does not equal MSGID
- busy  out  1  high from the cycle after start-accept until the GAP state ends
- sclk  out  1  SPI clock, CPOL=0
- mosi  out  1  SPI data out, MSB first
- miso  in  1  SPI data in
- sel  out  1  chip select, active low

Behaviour:
- Reset values: sel=1, sclk=0, mosi=1, busy=0, done=0, rx_valid=0, msgid_err=0, rx_data=0, state=IDLE.
- Reset mid-frame: all outputs take reset values on the next cycle; no done pulse is issued.
- Mode 0 only. sclk idles low and never falls before the first rising edge; a leading falling edge would corrupt the slave's first bit.
- States: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> HOLD -> GAP -> IDLE.
- IDLE:
  - start=1 latches tx_data into the shift register and clears the bit counter.
  - Next cycle: sel=0, mosi=tx_data[MSB], busy=1, enter SETUP.
  - start while busy is ignored and is not queued.
- SETUP: hold for CS_SETUP cycles with sclk=0, then enter SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles.
  - miso is sampled into the rx shift register (LSB-in, left-shift) on the first cycle sclk=1 is driven.
  - Bit counter increments at the end of SHIFT_HI.
- SHIFT_LO:
  - sclk=0 for CLK_DIV cycles.
  - On entry the tx shift register shifts left and mosi takes the new MSB.
  - When the counter reaches BUFFER_SIZE, SHIFT_HI exits to HOLD instead of SHIFT_LO. sclk=0 and mosi=1 on entry to HOLD.
- HOLD:
  - Lasts CS_HOLD cycles.
  - On the last cycle: rx_data <= rx shift register, done=1, rx_valid or msgid_err per header compare.
  - sel=1 on the next cycle.
- GAP: sel=1 for CS_GAP cycles, then IDLE with busy=0. A start in the IDLE cycle is accepted, giving back-to-back frames.
- Frame length: exactly BUFFER_SIZE sclk rising edges per frame; sclk period is 2*CLK_DIV.
- Counter: counter width is $clog2(BUFFER_SIZE+1). The counter never wraps within a frame.
- rx_data: holds its value across frames until the next done.
- Error frames: rx_data is updated even on msgid_err.

Decomposition:
- Package spi_frame_pkg: state enum; MSGID_W=32; function for the counter width.
- Sub-module spi_frame_clkgen: CLK_DIV phase counter producing rise_tick and fall_tick strobes, enabled by the FSM and cleared in IDLE.

Test Plan:
- Loopback against the slave (prog=0, slave tx_data=64'h74697277_DEADBEEF), master tx_data=64'h74697277_01020304, BUFFER_SIZE=64 -> slave sync=1 and slave rx_data=64'h74697277_01020304; master rx_data=64'h74697277_DEADBEEF, done=1, rx_valid=1.
- Slave reply 64'h00000000_12345678 -> done=1, msgid_err=1, rx_valid=0, rx_data=64'h00000000_12345678.
- Timing, CLK_DIV=4, CS_SETUP=4 -> 64 sclk rising edges, each high for 4 clk cycles; first rise exactly 4 cycles after sel falls; sclk is 0 whenever sel=1.
- Start pulsed on every cycle while busy=1 -> exactly one frame; next frame starts only at the IDLE cycle; sel high for >= 8 cycles between frames.
- rst asserted after bit 20 -> next cycle sel=1, sclk=0, mosi=1, busy=0; no done pulse; a following frame completes correctly.
- BUFFER_SIZE=32, tx_data=32'h74697277, slave tx_data=32'h74697277 -> rx_valid=1; 32 rising edges counted.
